// File: rtl/issue_scheduler.sv
// Issue scheduler: per-class round-robin pick of ready RS entries, CDB slot
// reservation so ALU and MUL results never collide, and a load sequencing FSM.
module issue_scheduler #(
    parameter int unsigned RS_SIZE = 8,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [RS_SIZE-1:0] i_req_alu,
    input  logic [RS_SIZE-1:0] i_req_mul,
    input  logic [RS_SIZE-1:0] i_req_ld,
    input  logic               i_ld_done,
    input  logic               i_squash,
    output logic [RS_SIZE-1:0] o_gnt_alu,
    output logic [RS_SIZE-1:0] o_gnt_mul,
    output logic [RS_SIZE-1:0] o_gnt_ld,
    output logic [1:0]         o_cdb_src,
    output logic               o_ld_ack
);

    localparam int unsigned PW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_MUL  = 2'd2;
    localparam logic [1:0] SRC_LD   = 2'd3;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_BUSY = 2'd1,
        LD_HOLD = 2'd2
    } ld_state_e;

    ld_state_e                r_ld_state;
    logic [PW-1:0]            r_ptr_alu;
    logic [PW-1:0]            r_ptr_mul;
    logic [PW-1:0]            r_ptr_ld;
    logic [MUL_LAT:0]         r_resv_v;
    logic [MUL_LAT:0][1:0]    r_resv_src;

    logic [MUL_LAT:0]         w_resv_v_nxt;
    logic [MUL_LAT:0][1:0]    w_resv_src_nxt;
    logic [PW:0]              w_pick_alu;
    logic [PW:0]              w_pick_mul;
    logic [PW:0]              w_pick_ld;
    logic                     w_en;
    logic                     w_alu_ok;
    logic                     w_mul_ok;
    logic                     w_ld_ok;
    logic                     w_ld_ack;

    // Returns {found, index} of the first request at or after ptr, wrapping.
    function automatic logic [PW:0] rr_pick(input logic [RS_SIZE-1:0] req,
                                            input logic [PW-1:0]      ptr);
        logic [PW:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            idx = ptr + PW'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign w_en       = i_rst_n & ~i_squash;
    assign w_pick_alu = rr_pick(i_req_alu, r_ptr_alu);
    assign w_pick_mul = rr_pick(i_req_mul, r_ptr_mul);
    assign w_pick_ld  = rr_pick(i_req_ld,  r_ptr_ld);

    // ALU result lands next cycle, so slot t+1 must be free of a MUL result.
    assign w_alu_ok = w_en & w_pick_alu[PW] & ~r_resv_v[1];
    assign w_mul_ok = w_en & w_pick_mul[PW];
    assign w_ld_ok  = w_en & w_pick_ld[PW] & (r_ld_state == LD_IDLE);

    assign o_gnt_alu = w_alu_ok ? (RS_SIZE'(1) << w_pick_alu[PW-1:0]) : '0;
    assign o_gnt_mul = w_mul_ok ? (RS_SIZE'(1) << w_pick_mul[PW-1:0]) : '0;
    assign o_gnt_ld  = w_ld_ok  ? (RS_SIZE'(1) << w_pick_ld[PW-1:0])  : '0;

    assign w_ld_ack = w_en & ~r_resv_v[0] &
                      (((r_ld_state == LD_BUSY) & i_ld_done) | (r_ld_state == LD_HOLD));
    assign o_ld_ack = w_ld_ack;

    always_comb begin
        o_cdb_src = SRC_NONE;
        if (w_en) begin
            if (r_resv_v[0])   o_cdb_src = r_resv_src[0];
            else if (w_ld_ack) o_cdb_src = SRC_LD;
        end
    end

    // Advance the reservation window by one slot and add this cycle's grants.
    always_comb begin
        w_resv_v_nxt   = '0;
        w_resv_src_nxt = '0;
        for (int k = 0; k < int'(MUL_LAT); k++) begin
            w_resv_v_nxt[k]   = r_resv_v[k+1];
            w_resv_src_nxt[k] = r_resv_src[k+1];
        end
        if (w_alu_ok) begin
            w_resv_v_nxt[0]   = 1'b1;
            w_resv_src_nxt[0] = SRC_ALU;
        end
        if (w_mul_ok) begin
            w_resv_v_nxt[MUL_LAT-1]   = 1'b1;
            w_resv_src_nxt[MUL_LAT-1] = SRC_MUL;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ld_state <= LD_IDLE;
            r_ptr_alu  <= '0;
            r_ptr_mul  <= '0;
            r_ptr_ld   <= '0;
            r_resv_v   <= '0;
            r_resv_src <= '0;
        end else if (i_squash) begin
            r_ld_state <= LD_IDLE;
            r_resv_v   <= '0;
            r_resv_src <= '0;
        end else begin
            r_resv_v   <= w_resv_v_nxt;
            r_resv_src <= w_resv_src_nxt;
            if (w_alu_ok) r_ptr_alu <= w_pick_alu[PW-1:0] + PW'(1);
            if (w_mul_ok) r_ptr_mul <= w_pick_mul[PW-1:0] + PW'(1);
            if (w_ld_ok)  r_ptr_ld  <= w_pick_ld[PW-1:0]  + PW'(1);
            case (r_ld_state)
                LD_IDLE: if (w_ld_ok) r_ld_state <= LD_BUSY;
                LD_BUSY: if (i_ld_done) r_ld_state <= r_resv_v[0] ? LD_HOLD : LD_IDLE;
                LD_HOLD: if (!r_resv_v[0]) r_ld_state <= LD_IDLE;
                default: r_ld_state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Issue scheduler between the reservation station and the functional units. Each cycle it picks at most one ready RS entry for each FU class (ALU, MUL, LD) using per-class round-robin. It reserves the single CDB slot in which each result will broadcast, so that ALU and MUL results never collide. A small FSM sequences the variable-latency load unit onto free CDB slots.

## Interface
- RS_SIZE, 8: number of RS entries; power of two, ≥2.
- MUL_LAT, 4: multiplier latency, cycles from grant to CDB broadcast; ≥2.
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- req_alu  in  RS_SIZE  entry i is ready and is an ALU op.
- req_mul  in  RS_SIZE  entry i is ready and is a MUL op.
- req_ld  in  RS_SIZE  entry i is ready and is a load.
- ld_done  in  1  load unit has its result this cycle.
- squash  in  1  branch mispredict flush.
- gnt_alu  out  RS_SIZE  one-hot or zero; ALU grant (combinational).
- gnt_mul  out  RS_SIZE  one-hot or zero; MUL grant.
- gnt_ld  out  RS_SIZE  one-hot or zero; LD grant.
- cdb_src  out  2  CDB owner this cycle: 0 none, 1 ALU, 2 MUL, 3 LD.
- ld_ack  out  1  load result accepted onto CDB this cycle.

## Operation
- **Grants.** Grants are combinational from requests and state. RS clears a granted entry at the next edge. A grant bit is only ever set where the matching req bit is 1.
- **Round-robin.** Each class has a pointer ptr_x (log2 RS_SIZE bits).
  - Search starts at ptr_x and wraps modulo RS_SIZE.
  - After a grant to entry i, ptr_x ← (i+1) mod RS_SIZE.
  - With no grant, ptr_x holds.
- **CDB reservation.** Vector resv[0..MUL_LAT], each bit with a 2-bit src tag.
  - resv[k]=1 means the CDB is owned k cycles from now. resv[0] is the current cycle; cdb_src = resv[0] ? src[0] : (ld_ack ? 3 : 0).
  - MUL grant: allowed whenever req_mul≠0, since slot MUL_LAT is never pre-reserved. It sets the slot that becomes resv[MUL_LAT-1] after the shift, i.e. CDB at t+MUL_LAT.
  - ALU grant: allowed only if resv[1]==0, i.e. slot t+1 free. It sets next resv[0] with src 1.
  - Shift: resv_next[k] = resv[k+1] | new reservations; resv_next[MUL_LAT] = 0.
  - An ALU request blocked by a MUL reservation gets no grant, and its pointer holds.
- **Load FSM** (one load in flight):
  - LD_IDLE: gnt_ld may assert; on grant → LD_BUSY.
  - LD_BUSY: wait for ld_done.
    - ld_done & resv[0]==0: ld_ack=1, cdb_src=3 this cycle, → LD_IDLE.
    - ld_done & resv[0]==1: → LD_HOLD.
  - LD_HOLD: each cycle, if resv[0]==0 then ld_ack=1, cdb_src=3, → LD_IDLE; else stay.
  - gnt_ld is 0 in LD_BUSY and LD_HOLD.
  - ld_done outside LD_BUSY is ignored.
- **Squash.**
  - Combinationally forces all gnt_* = 0 and ld_ack = 0.
  - At the edge: resv cleared, load FSM → LD_IDLE, pointers hold.
  - A result already on the CDB in the squash cycle is suppressed: cdb_src=0 while squash=1.

## Timing
- Reset values:
  - ptr_alu/mul/ld = 0, resv = 0, load FSM = LD_IDLE.
  - gnt_* = 0 with no requests; cdb_src = 0; ld_ack = 0.
- Latencies: grant at cycle t gives ALU result on CDB at t+1 and MUL result at t+MUL_LAT. A load reaches the CDB in the first cycle with ld_done (or in LD_HOLD) and resv[0]==0.
- Per cycle: at most one grant per class, up to 3 grants in total. CDB has exactly one owner per cycle, with priority resv slot > load.
- Simultaneous ALU and MUL grants are legal, since they target different slots.
- Pointer wrap: a grant at entry RS_SIZE-1 sets the pointer to 0.
- Reset asserted mid-operation: all state clears asynchronously and in-flight reservations are lost. Outputs take reset values while reset==0.

## Test plan
- **Reset.** Hold reset=0 with requests asserted → all gnt_*=0, cdb_src=0. Release → first ALU grant goes to the lowest requesting index.
- **Round-robin.** req_alu=8'hFF for 9 cycles, MUL idle → gnt_alu = 01,02,04,…,80,01. cdb_src=1 from cycle 2 onward.
- **ALU/MUL collision.** MUL grant at t with MUL_LAT=4; req_alu held → gnt_alu=0 at t+3, grant at t+4. cdb_src=2 at t+4, 1 at t+5.
- **Load hold.** Load granted, ld_done at the same cycle as a MUL slot (resv[0]=1) → ld_ack=0 and FSM enters LD_HOLD. Next cycle, with the slot free → ld_ack=1, cdb_src=3. No gnt_ld until back in LD_IDLE.
- **Squash.** MUL in flight and load in LD_BUSY, squash=1 → gnt_*=0, cdb_src=0. Next cycle resv=0, FSM in LD_IDLE, pointers unchanged.
- **Mid-operation reset.** Assert reset=0 asynchronously between edges with reservations pending → cdb_src=0 immediately and stays 0 after release until a new grant.
